// File: rtl/iserdes_bitslip_deser_pkg.sv
// Shared constants and helpers for the bit-slip deserializer.
// The counter width is derived here so the top and any bench agree.
package iserdes_bitslip_deser_pkg;

   localparam int DATA_WIDTH_MIN = 2;
   localparam int DATA_WIDTH_MAX = 8;

   // Width of the in-word bit counter; it counts 0..width-1.
   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/iserdes_bitslip_deser_if.sv
// Serial-in / word-out bundle of the deserializer.
// The master drives the serial side; the slave (the deserializer) returns words.
interface iserdes_bitslip_deser_if #(
   parameter int DATA_WIDTH = 4
);
   logic                  ce;
   logic                  d;
   logic                  bitslip;
   logic                  o;
   logic [DATA_WIDTH-1:0] q;
   logic                  q_valid;

   modport master (output ce, d, bitslip, input o, q, q_valid);
   modport slave  (input ce, d, bitslip, output o, q, q_valid);
endinterface

// File: rtl/iserdes_bitslip_deser_edge_det.sv
// Rising-edge detector for the bitslip request line.
// History updates every cycle regardless of clock enable, so an edge seen while disabled is consumed.
module bitslip_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic bitslip,
   output logic slip_req
);

   logic bs_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         bs_q <= 1'b0;
      end else begin
         bs_q <= bitslip;
      end
   end

   assign slip_req = bitslip & ~bs_q;

endmodule

// File: rtl/iserdes_bitslip_deser.sv
// Serial-to-parallel deserializer with bit-slip word alignment.
// A slip cycle still shifts d in but holds the bit counter, pushing word boundaries one bit later.
module iserdes_bitslip_deser
   import iserdes_bitslip_deser_pkg::*;
#(
   parameter int DATA_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   iserdes_bitslip_deser_if.slave bus
);

   localparam int              CNT_W   = cnt_width(DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] sr;
   logic [DATA_WIDTH-1:0] q;
   logic [DATA_WIDTH-1:0] sr_next;
   logic [CNT_W-1:0]      cnt;
   logic                  q_valid;
   logic                  slip_req;

   bitslip_edge_det u_edge_det (
      .clk      (clk),
      .rst      (rst),
      .bitslip  (bus.bitslip),
      .slip_req (slip_req)
   );

   // Newest bit enters at the LSB so the first-received bit ends up at the MSB.
   assign sr_next = {sr[DATA_WIDTH-2:0], bus.d};

   always_ff @(posedge clk) begin
      if (rst) begin
         sr      <= '0;
         cnt     <= '0;
         q       <= '0;
         q_valid <= 1'b0;
      end else begin
         q_valid <= 1'b0;
         if (bus.ce) begin
            sr <= sr_next;
            if (!slip_req) begin
               if (cnt == CNT_MAX) begin
                  q       <= sr_next;
                  q_valid <= 1'b1;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
         end
      end
   end

   assign bus.q       = q;
   assign bus.q_valid = q_valid;
   assign bus.o       = bus.d;

endmodule

// File: tb/tb_iserdes_bitslip_deser.sv
// Scoreboard bench for iserdes_bitslip_deser: directed alignment scenarios followed by random traffic.
module tb_iserdes_bitslip_deser;

   localparam int W = 4;

   typedef struct {
      int           cyc;
      logic [W-1:0] q;
      logic         v;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   end_req = 0;

   exp_t sb[$];
   exp_t mon_e;

   // Reference model state: recent enabled bits, bits since last word, last word, prior bitslip level.
   bit           m_hist[$];
   int           m_since = 0;
   logic [W-1:0] m_q = '0;
   bit           m_prev = 0;

   logic [W-1:0] pat = '0;
   int           pidx = 0;

   iserdes_bitslip_deser_if #(.DATA_WIDTH(W)) bus ();

   iserdes_bitslip_deser #(.DATA_WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: checks passthrough every cycle and pops the expectation for the current cycle.
   always @(negedge clk) begin
      n_chk++;
      if (bus.o !== bus.d) begin
         n_fail++;
         $display("FAIL o_passthru cyc=%0d: o=%b expected %b", cyc, bus.o, bus.d);
      end
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         mon_e = sb.pop_front();
         n_chk++;
         n_fail++;
         $display("FAIL stale_expect: entry for cyc %0d unchecked at cyc %0d", mon_e.cyc, cyc);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         mon_e = sb.pop_front();
         n_chk++;
         if (bus.q_valid !== mon_e.v) begin
            n_fail++;
            $display("FAIL q_valid cyc=%0d: got %b expected %b", cyc, bus.q_valid, mon_e.v);
         end
         n_chk++;
         if (bus.q !== mon_e.q) begin
            n_fail++;
            $display("FAIL q cyc=%0d: got %h expected %h", cyc, bus.q, mon_e.q);
         end
      end
      if (end_req) begin
         n_chk++;
         if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
         end
      end
   end

   // Applies one cycle of inputs, advances the model for the coming edge, then waits past that edge.
   task automatic drive(input bit r, input bit c, input bit dd, input bit b);
      exp_t         e;
      bit           slip;
      logic [W-1:0] word;
      rst        = r;
      bus.ce     = c;
      bus.d      = dd;
      bus.bitslip = b;
      e.cyc = cyc + 1;
      e.v   = 1'b0;
      if (r) begin
         m_prev  = 0;
         m_since = 0;
         m_q     = '0;
         m_hist.delete();
      end else begin
         slip   = b && !m_prev;
         m_prev = b;
         if (c) begin
            m_hist.push_back(dd);
            if (m_hist.size() > W) void'(m_hist.pop_front());
            if (!slip) begin
               m_since++;
               if (m_since == W) begin
                  word = '0;
                  foreach (m_hist[i]) word = {word[W-2:0], m_hist[i]};
                  m_q     = word;
                  m_since = 0;
                  e.v     = 1'b1;
               end
            end
         end
      end
      e.q = m_q;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Sends the next bit of the repeating pattern; the pattern position advances only when enabled.
   task automatic drive_bit(input bit c, input bit b);
      drive(0, c, pat[W-1-pidx], b);
      if (c) pidx = (pidx + 1) % W;
   endtask

   task automatic send_word(input logic [W-1:0] w);
      pat = w;
      repeat (W) drive_bit(1, 0);
   endtask

   task automatic finish_word();
      while (pidx != 0) drive_bit(1, 0);
   endtask

   initial begin
      bus.ce      = 1'b0;
      bus.d       = 1'b0;
      bus.bitslip = 1'b0;

      // Reset, then a steady 4'ha stream.
      drive(1, 1, 1, 0);
      drive(1, 1, 0, 1);
      pat  = 4'ha;
      pidx = 0;
      repeat (6) send_word(4'ha);

      // Misaligned 4'h1 stream; slip until the model word matches.
      pat  = 4'h1;
      pidx = 2;
      finish_word();
      repeat (2) send_word(4'h1);
      for (int k = 0; k < W && m_q != 4'h1; k++) begin
         drive_bit(1, 1);
         drive_bit(1, 0);
         finish_word();
         repeat (2) send_word(4'h1);
      end

      // Distinct words, then one more slip moves the boundary one bit later.
      send_word(4'h8);
      send_word(4'h4);
      send_word(4'h2);
      send_word(4'h1);
      drive_bit(1, 1);
      drive_bit(1, 0);
      finish_word();
      repeat (3) send_word(4'h1);

      // Bitslip held high for 10 cycles, then a fresh edge.
      pat = 4'h6;
      repeat (10) drive_bit(1, 1);
      repeat (2) drive_bit(1, 0);
      drive_bit(1, 1);
      repeat (12) drive_bit(1, 0);

      // Clock enable dropped mid-word with a bitslip edge inside the gap.
      finish_word();
      pat = 4'hc;
      drive_bit(1, 0);
      drive_bit(1, 0);
      drive_bit(0, 0);
      drive_bit(0, 1);
      drive_bit(0, 0);
      repeat (10) drive_bit(1, 0);

      // Reset two bits into a word, then resume.
      finish_word();
      pat = 4'h5;
      drive_bit(1, 0);
      drive_bit(1, 0);
      drive(1, 1, 1, 0);
      pidx = 0;
      repeat (4) send_word(4'h9);
      repeat (3) send_word(4'h3);

      // Random traffic.
      for (int i = 0; i < 500; i++) begin
         drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
               1'($urandom), ($urandom_range(0, 4) == 0));
      end
      drive(0, 0, 0, 0);

      end_req = 1;
      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
